// File: rtl/demux_4_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_4_stream_pkg
// Description : Shared constants and types for the 1-to-4 stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_4_stream_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;

  // Occupancy of a one-entry output slot
  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage : demux_4_stream_pkg
`default_nettype wire

// File: rtl/demux_4_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_4_stream_if
// Description : Producer-side and consumer-side stream signals of the demux.
//               The slave modport is the demux view; master is the bench view.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_4_stream_if #(
  parameter int W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [4*W-1:0]   out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface : demux_4_stream_if
`default_nettype wire

// File: rtl/demux_4_stream_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry registered buffer for a single output channel.
//               A push in the same cycle as a pop replaces the held word.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
  import demux_4_stream_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  slot_state_t  state_q, state_d;
  logic [W-1:0] data_q,  data_d;

  // Next occupancy and data: push wins over pop so pop+push stays full
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (push) begin
      state_d = SLOT_FULL;
      data_d  = d;
    end else if (pop) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot registers; data keeps the last word after the slot drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign q     = data_q;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_4_stream
// Description : 1-to-4 valid/ready stream demultiplexer. Each channel owns a
//               one-entry slot so a stalled consumer blocks only its own
//               channel. Optional per-channel saturating pop counters are
//               enabled with DEMUX_4_STREAM_COUNT_EN (adds port cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module demux_4_stream
  import demux_4_stream_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  demux_4_stream_if.slave         bus
`ifdef DEMUX_4_STREAM_COUNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0]  cnt
`endif
);

  logic [N_OUT-1:0] w_push;
  logic [N_OUT-1:0] w_pop;
  logic [N_OUT-1:0] w_out_valid;
  logic             w_slot_valid [N_OUT];
  logic [W-1:0]     w_slot_q     [N_OUT];
  logic             w_in_ready;

  // A word may enter when its target slot is empty or draining this cycle
  assign w_in_ready   = ~w_out_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign bus.in_ready = w_in_ready;

  // Select decode into per-channel push, and per-channel pop qualification
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      w_push[k] = bus.in_valid & w_in_ready & (bus.in_sel == sel_t'(k));
      w_pop[k]  = w_out_valid[k] & bus.out_ready[k];
    end
  end

  // Pack slot outputs onto the channel bus
  always_comb begin
    bus.out_data = '0;
    w_out_valid  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      w_out_valid[k]       = w_slot_valid[k];
      bus.out_data[k*W +: W] = w_slot_q[k];
    end
  end

  assign bus.out_valid = w_out_valid;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .W (W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[k]),
      .pop   (w_pop[k]),
      .d     (bus.in_data),
      .valid (w_slot_valid[k]),
      .q     (w_slot_q[k])
    );
  end : g_slot

`ifdef DEMUX_4_STREAM_COUNT_EN
  logic [CNT_W-1:0] w_cnt [N_OUT];

  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count pops, holding at all-ones instead of wrapping
    always_comb begin
      cnt_d = cnt_q;
      if (w_pop[k] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign w_cnt[k] = cnt_q;
  end : g_cnt

  // Pack counters onto the cnt port
  always_comb begin
    cnt = '0;
    for (int k = 0; k < N_OUT; k++) begin
      cnt[k*CNT_W +: CNT_W] = w_cnt[k];
    end
  end
`endif

endmodule : demux_4_stream
`default_nettype wire
